// File: rtl/alu_serial_rx.sv
// rtl/alu_serial_rx.sv - serial frame receiver: operands, opcode, framing/count/CRC-4/timeout checks
module alu_serial_rx #(
    parameter int OPW     = 32,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] a,
    output logic [OPW-1:0] b,
    output logic [2:0]     op,
    output logic           err_frame,
    output logic           err_data,
    output logic           err_crc,
    output logic           err_timeout,
    output logic           overrun
);

    localparam int             N       = 2 * OPW / 8;
    localparam int             CW      = $clog2(N + 2);
    localparam logic [CW-1:0]  N_CNT   = CW'(N);
    localparam logic [CW-1:0]  N_SAT   = CW'(N + 1);
    localparam logic [9:0]     TO_LAST = 10'(TIMEOUT - 1);
    localparam logic           ST_IDLE  = 1'b0;
    localparam logic           ST_SHIFT = 1'b1;

    // One step of the x^4+x+1 CRC, MSB-first input.
    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
        logic fb;
        fb = c[3] ^ d;
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    // Fold one payload byte into the running CRC, MSB first.
    function automatic logic [3:0] crc_byte(input logic [3:0] c, input logic [7:0] d);
        logic [3:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) r = crc_step(r, d[i]);
        return r;
    endfunction

    logic             state;
    logic [3:0]       bit_cnt;
    logic [8:0]       pkt;
    logic [2*OPW-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [3:0]       crc;
    logic [9:0]       idle_cnt;

    // Record staged on the evaluation edge, presented to the output buffer one cycle later.
    logic             rec_pend;
    logic [OPW-1:0]   rec_a;
    logic [OPW-1:0]   rec_b;
    logic [2:0]       rec_op;
    logic             rec_ef;
    logic             rec_ed;
    logic             rec_ec;
    logic             rec_et;

    // Frame CRC closed out with the '1' marker bit and the received opcode.
    logic [3:0] cmd_crc;
    always_comb begin
        cmd_crc = crc_step(crc, 1'b1);
        cmd_crc = crc_step(cmd_crc, pkt[6]);
        cmd_crc = crc_step(cmd_crc, pkt[5]);
        cmd_crc = crc_step(cmd_crc, pkt[4]);
    end

    // Packet FSM, frame accumulation, idle timeout and record generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            pkt      <= 9'd0;
            sreg     <= '0;
            cnt      <= '0;
            crc      <= 4'd0;
            idle_cnt <= 10'd0;
            rec_pend <= 1'b0;
            rec_a    <= '0;
            rec_b    <= '0;
            rec_op   <= 3'd0;
            rec_ef   <= 1'b0;
            rec_ed   <= 1'b0;
            rec_ec   <= 1'b0;
            rec_et   <= 1'b0;
        end else begin
            rec_pend <= 1'b0;
            rec_a    <= '0;
            rec_b    <= '0;
            rec_op   <= 3'd0;
            rec_ef   <= 1'b0;
            rec_ed   <= 1'b0;
            rec_ec   <= 1'b0;
            rec_et   <= 1'b0;
            if (state == ST_IDLE) begin
                if (!sin) begin
                    state    <= ST_SHIFT;
                    bit_cnt  <= 4'd0;
                    idle_cnt <= 10'd0;
                end else if (cnt == '0) begin
                    idle_cnt <= 10'd0;
                end else if (idle_cnt == TO_LAST) begin
                    idle_cnt <= 10'd0;
                    cnt      <= '0;
                    crc      <= 4'd0;
                    sreg     <= '0;
                    rec_pend <= 1'b1;
                    rec_et   <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 10'd1;
                end
            end else if (bit_cnt != 4'd9) begin
                pkt     <= {pkt[7:0], sin};
                bit_cnt <= bit_cnt + 4'd1;
            end else begin
                // Stop-bit edge: the packet is complete in pkt, sin holds the stop bit.
                state <= ST_IDLE;
                if (!sin) begin
                    cnt      <= '0;
                    crc      <= 4'd0;
                    sreg     <= '0;
                    rec_pend <= 1'b1;
                    rec_ef   <= 1'b1;
                end else if (pkt[8]) begin
                    cnt      <= '0;
                    crc      <= 4'd0;
                    sreg     <= '0;
                    rec_pend <= 1'b1;
                    if (cnt != N_CNT) begin
                        rec_ed <= 1'b1;
                    end else if (cmd_crc != pkt[3:0]) begin
                        rec_ec <= 1'b1;
                    end else begin
                        rec_a  <= sreg[2*OPW-1:OPW];
                        rec_b  <= sreg[OPW-1:0];
                        rec_op <= pkt[6:4];
                    end
                end else begin
                    sreg <= {sreg[2*OPW-9:0], pkt[7:0]};
                    crc  <= crc_byte(crc, pkt[7:0]);
                    if (cnt != N_SAT) cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // One-deep output buffer; a record arriving while the held one is stalled is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            a           <= '0;
            b           <= '0;
            op          <= 3'd0;
            err_frame   <= 1'b0;
            err_data    <= 1'b0;
            err_crc     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rec_pend) begin
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    out_valid   <= 1'b1;
                    a           <= rec_a;
                    b           <= rec_b;
                    op          <= rec_op;
                    err_frame   <= rec_ef;
                    err_data    <= rec_ed;
                    err_crc     <= rec_ec;
                    err_timeout <= rec_et;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_rx.sv
// tb/tb_alu_serial_rx.sv - directed self-checking bench for alu_serial_rx
module tb_alu_serial_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        sin32, sin8, sin64;
    logic        rdy32, rdy8, rdy64;

    logic        v32, ef32, ed32, ec32, et32, ov32;
    logic [31:0] a32, b32;
    logic [2:0]  op32;
    logic        v8, ef8, ed8, ec8, et8, ov8;
    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic        v64, ef64, ed64, ec64, et64, ov64;
    logic [63:0] a64, b64;
    logic [2:0]  op64;

    alu_serial_rx #(.OPW(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .sin(sin32), .out_valid(v32), .out_ready(rdy32),
        .a(a32), .b(b32), .op(op32), .err_frame(ef32), .err_data(ed32),
        .err_crc(ec32), .err_timeout(et32), .overrun(ov32));

    alu_serial_rx #(.OPW(8), .TIMEOUT(64)) dut8 (
        .clk(clk), .rst_n(rst_n), .sin(sin8), .out_valid(v8), .out_ready(rdy8),
        .a(a8), .b(b8), .op(op8), .err_frame(ef8), .err_data(ed8),
        .err_crc(ec8), .err_timeout(et8), .overrun(ov8));

    alu_serial_rx #(.OPW(64), .TIMEOUT(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .sin(sin64), .out_valid(v64), .out_ready(rdy64),
        .a(a64), .b(b64), .op(op64), .err_frame(ef64), .err_data(ed64),
        .err_crc(ec64), .err_timeout(et64), .overrun(ov64));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC over {A, B, 1, op}, walking the whole bit string MSB first.
    function automatic logic [3:0] model_crc(input logic [127:0] ab, input int nbits, input logic [2:0] opc);
        logic [3:0] c;
        logic [3:0] tail;
        logic       fb;
        c    = 4'd0;
        tail = {1'b1, opc};
        for (int i = nbits - 1; i >= 0; i--) begin
            fb = c[3] ^ ab[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        for (int i = 3; i >= 0; i--) begin
            fb = c[3] ^ tail[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    task automatic set_line(input int w, input logic v);
        if (w == 8) sin8 = v;
        else if (w == 64) sin64 = v;
        else sin32 = v;
    endtask

    task automatic send_bit(input int w, input logic v);
        set_line(w, v);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int w, input logic ty, input logic [7:0] pl, input logic stop);
        send_bit(w, 1'b0);
        send_bit(w, ty);
        for (int i = 7; i >= 0; i--) send_bit(w, pl[i]);
        send_bit(w, stop);
        set_line(w, 1'b1);
    endtask

    task automatic send_data(input int w, input logic [127:0] ab, input int nbytes);
        for (int k = 0; k < nbytes; k++) send_pkt(w, 1'b0, ab[(nbytes-1-k)*8 +: 8], 1'b1);
    endtask

    task automatic send_cmd(input int w, input logic [2:0] opc, input logic [3:0] c);
        send_pkt(w, 1'b1, {1'b0, opc, c}, 1'b1);
    endtask

    // Called just after the last stop edge: record must appear exactly one edge later.
    task automatic expect32(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [2:0] eop, input logic [3:0] eflags);
        chk({tag, "_pre_valid"}, 64'(v32), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 64'(v32), 64'd1);
        chk({tag, "_a"}, 64'(a32), 64'(ea));
        chk({tag, "_b"}, 64'(b32), 64'(eb));
        chk({tag, "_op"}, 64'(op32), 64'(eop));
        chk({tag, "_flags"}, 64'({ef32, ed32, ec32, et32}), 64'(eflags));
    endtask

    task automatic accept32(input string tag);
        rdy32 = 1'b1;
        @(posedge clk);
        #1;
        rdy32 = 1'b0;
        chk({tag, "_accepted"}, 64'(v32), 64'd0);
    endtask

    task automatic good32(input string tag, input logic [31:0] ga, input logic [31:0] gb, input logic [2:0] gop);
        send_data(32, {64'd0, ga, gb}, 8);
        send_cmd(32, gop, model_crc({64'd0, ga, gb}, 64, gop));
        expect32(tag, ga, gb, gop, 4'b0000);
    endtask

    int c0;

    initial begin
        rst_n = 1'b0;
        sin32 = 1'b1; sin8 = 1'b1; sin64 = 1'b1;
        rdy32 = 1'b0; rdy8 = 1'b1; rdy64 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(v32), 64'd0);
        chk("reset_ab", 64'({a32, b32}), 64'd0);
        chk("reset_op_flags", 64'({op32, ef32, ed32, ec32, et32, ov32}), 64'd0);
        rst_n = 1'b1;

        // Idle line must never produce a record.
        repeat (80) @(posedge clk);
        #1;
        chk("idle_no_record", 64'(v32), 64'd0);

        // Good all-zero frame, crc 4'b1011; valid on the 100th edge counting the start edge.
        c0 = cyc;
        send_data(32, 128'd0, 8);
        send_cmd(32, 3'b000, 4'b1011);
        expect32("good_zero", 32'd0, 32'd0, 3'd0, 4'b0000);
        chk("good_zero_latency", 64'(cyc - c0), 64'd100);
        accept32("good_zero");

        // Bad CRC.
        send_data(32, 128'd0, 8);
        send_cmd(32, 3'b000, 4'b1010);
        expect32("bad_crc", 32'd0, 32'd0, 3'd0, 4'b0010);
        accept32("bad_crc");

        // Short and long frames.
        send_data(32, 128'd0, 7);
        send_cmd(32, 3'b000, 4'b1011);
        expect32("short", 32'd0, 32'd0, 3'd0, 4'b0100);
        accept32("short");
        send_data(32, 128'd0, 9);
        send_cmd(32, 3'b000, 4'b1011);
        expect32("extra", 32'd0, 32'd0, 3'd0, 4'b0100);
        accept32("extra");

        // Non-trivial operands.
        good32("good_mix", 32'h1234_5678, 32'h9ABC_DEF0, 3'd5);
        accept32("good_mix");

        // Framing error on the 3rd data packet, then a good frame.
        send_data(32, 128'h1122, 2);
        send_pkt(32, 1'b0, 8'h55, 1'b0);
        expect32("frame_err", 32'd0, 32'd0, 3'd0, 4'b1000);
        accept32("frame_err");
        good32("after_frame", 32'hCAFE_0001, 32'h0000_BEEF, 3'd7);
        accept32("after_frame");

        // Timeout: 2 data packets, then idle; record on the edge after the 64th idle cycle.
        send_data(32, 128'hA5A5, 2);
        repeat (64) @(posedge clk);
        #1;
        expect32("timeout", 32'd0, 32'd0, 3'd0, 4'b0001);
        accept32("timeout");
        good32("after_timeout", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'd2);
        accept32("after_timeout");

        // Backpressure: second record dropped with a one-cycle overrun pulse.
        good32("bp_first", 32'd1, 32'd2, 3'd1);
        send_data(32, {64'd0, 32'd3, 32'd4}, 8);
        send_cmd(32, 3'd2, model_crc({64'd0, 32'd3, 32'd4}, 64, 3'd2));
        chk("ovr_pre", 64'(ov32), 64'd0);
        @(posedge clk);
        #1;
        chk("ovr_pulse", 64'(ov32), 64'd1);
        chk("ovr_held_valid", 64'(v32), 64'd1);
        chk("ovr_held_a", 64'(a32), 64'd1);
        @(posedge clk);
        #1;
        chk("ovr_pulse_end", 64'(ov32), 64'd0);
        chk("ovr_held_b", 64'(b32), 64'd2);

        // Accept in the same cycle a new record lands: new one loads, valid stays high.
        send_data(32, {64'd0, 32'd5, 32'd6}, 8);
        send_cmd(32, 3'd3, model_crc({64'd0, 32'd5, 32'd6}, 64, 3'd3));
        rdy32 = 1'b1;
        @(posedge clk);
        #1;
        rdy32 = 1'b0;
        chk("swap_valid", 64'(v32), 64'd1);
        chk("swap_a", 64'(a32), 64'd5);
        chk("swap_op", 64'(op32), 64'd3);
        chk("swap_no_ovr", 64'(ov32), 64'd0);

        // Reset mid-packet with a record held.
        send_bit(32, 1'b0);
        send_bit(32, 1'b0);
        send_bit(32, 1'b1);
        send_bit(32, 1'b0);
        rst_n = 1'b0;
        sin32 = 1'b1;
        #2;
        chk("rst_mid_valid", 64'(v32), 64'd0);
        chk("rst_mid_ab", 64'({a32, b32}), 64'd0);
        chk("rst_mid_op", 64'(op32), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_record", 64'(v32), 64'd0);
        good32("after_reset", 32'hDEAD_BEEF, 32'h0123_4567, 3'd6);
        accept32("after_reset");

        // OPW=8: 33-cycle frame, valid on the 34th edge counting the start edge.
        c0 = cyc;
        send_data(8, 128'h3CA7, 2);
        send_cmd(8, 3'd4, model_crc(128'h3CA7, 16, 3'd4));
        chk("w8_pre_valid", 64'(v8), 64'd0);
        @(posedge clk);
        #1;
        chk("w8_latency", 64'(cyc - c0), 64'd34);
        chk("w8_valid", 64'(v8), 64'd1);
        chk("w8_ab", 64'({a8, b8}), 64'h3CA7);
        chk("w8_op_flags", 64'({op8, ef8, ed8, ec8, et8}), 64'({3'd4, 4'b0000}));

        // OPW=64.
        send_data(64, {64'hFEDC_BA98_7654_3210, 64'h0011_2233_4455_6677}, 16);
        send_cmd(64, 3'd1, model_crc({64'hFEDC_BA98_7654_3210, 64'h0011_2233_4455_6677}, 128, 3'd1));
        chk("w64_pre_valid", 64'(v64), 64'd0);
        @(posedge clk);
        #1;
        chk("w64_valid", 64'(v64), 64'd1);
        chk("w64_a", a64, 64'hFEDC_BA98_7654_3210);
        chk("w64_b", b64, 64'h0011_2233_4455_6677);
        chk("w64_op_flags", 64'({op64, ef64, ed64, ec64, et64}), 64'({3'd1, 4'b0000}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
